// File: rtl/seq_detector_param.sv
// Parametrised Mealy sequence detector for a serial bit stream.
// Pattern length is fixed at elaboration. The pattern and overlap mode can be
// reloaded at run time. Matches are counted in a saturating counter.
module seq_detector_param #(
  parameter int unsigned      N           = 4,
  parameter logic [N-1:0]     DEF_PATTERN = 4'b0101,
  parameter bit               DEF_OVERLAP = 1'b1,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             d_valid,
  input  logic             d_in,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FW      = $clog2(N);
  localparam logic [FW-1:0]    FillMax = FW'(N - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pattern_q, pattern_d;
  logic             overlap_q, overlap_d;
  logic             match_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     window;

  // Match decode and next-state; clear beats cfg_load beats d_valid.
  always_comb begin
    window    = {hist_q, d_in};
    match     = d_valid & ~clear & ~cfg_load & (fill_q == FillMax) & (window == pattern_q);
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    cnt_d     = cnt_q;
    match_q_d = match;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (d_valid) begin
      if (match && !overlap_q) begin
        // Non-overlapping mode: the next match needs N fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[N-2:0];
        fill_d = (fill_q == FillMax) ? FillMax : fill_q + FW'(1);
      end
      if (match && cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      overlap_q <= DEF_OVERLAP;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      match_q   <= match_q_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cnt_sat   = (cnt_q == CntMax);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=2) share the same stimulus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear, cfg_load, cfg_overlap, d_valid, d_in;
  logic [3:0] cfg_pattern;
  logic       match, match_q, cnt_sat;
  logic [7:0] match_cnt;
  logic       match2, match_q2, cnt_sat2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .d_valid    (d_valid),
    .d_in       (d_in),
    .match      (match),
    .match_q    (match_q),
    .match_cnt  (match_cnt),
    .cnt_sat    (cnt_sat)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .d_valid    (d_valid),
    .d_in       (d_in),
    .match      (match2),
    .match_q    (match_q2),
    .match_cnt  (match_cnt2),
    .cnt_sat    (cnt_sat2)
  );

  task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus starting at a falling edge; match checked before the
  // rising edge, match_q checked just after it.
  task automatic step(input logic clr, input logic ld, input logic [3:0] pat,
                      input logic ovl, input logic v, input logic din,
                      input logic exp_m, input string tag);
    clear       = clr;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    d_valid     = v;
    d_in        = din;
    #1;
    chk(8'(match), 8'(exp_m), tag);
    @(posedge clk);
    #1;
    chk(8'(match_q), 8'(exp_m), {tag, "_q"});
    clear    = 1'b0;
    cfg_load = 1'b0;
    d_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic bit_in(input logic din, input logic exp_m, input string tag);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, din, exp_m, tag);
  endtask

  task automatic idle(input logic din);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, din, 1'b0, "gap");
  endtask

  task automatic load(input logic [3:0] pat, input logic ovl, input logic v, input logic din);
    step(1'b0, 1'b1, pat, ovl, v, din, 1'b0, "load");
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'h0;
    cfg_overlap = 1'b0; d_valid = 1'b0; d_in = 1'b0;
    @(negedge clk); @(negedge clk);
    chk(8'(match), 8'h0, "rst_match");
    chk(8'(match_q), 8'h0, "rst_match_q");
    chk(match_cnt, 8'h0, "rst_cnt");
    chk(8'(cnt_sat), 8'h0, "rst_sat");
    reset_n = 1'b1;
    @(negedge clk);

    // 1: defaults 0101 overlapping
    bit_in(0, 0, "t1_b1"); bit_in(1, 0, "t1_b2"); bit_in(0, 0, "t1_b3");
    bit_in(1, 1, "t1_b4"); bit_in(0, 0, "t1_b5"); bit_in(1, 1, "t1_b6");
    chk(match_cnt, 8'd2, "t1_cnt");

    // 2: non-overlapping 0101
    load(4'b0101, 1'b0, 1'b0, 1'b0);
    bit_in(0, 0, "t2_b1"); bit_in(1, 0, "t2_b2"); bit_in(0, 0, "t2_b3");
    bit_in(1, 1, "t2_b4"); bit_in(0, 0, "t2_b5"); bit_in(1, 0, "t2_b6");
    bit_in(0, 0, "t2_b7"); bit_in(1, 1, "t2_b8");
    chk(match_cnt, 8'd4, "t2_cnt");
    chk(8'(match_cnt2), 8'd3, "t2_cnt2_sat");
    chk(8'(cnt_sat2), 8'd1, "t2_sat2");

    // 3: gaps with toggling d_in are transparent
    load(4'b0101, 1'b1, 1'b0, 1'b0);
    bit_in(0, 0, "t3_b1"); idle(1);
    bit_in(1, 0, "t3_b2"); idle(0); idle(1);
    bit_in(0, 0, "t3_b3"); idle(1); idle(0); idle(1);
    bit_in(1, 1, "t3_b4");
    chk(match_cnt, 8'd5, "t3_cnt");

    // 4: self-overlapping 1111, then load coinciding with a valid bit
    load(4'b1111, 1'b1, 1'b0, 1'b0);
    bit_in(1, 0, "t4_b1"); bit_in(1, 0, "t4_b2"); bit_in(1, 0, "t4_b3");
    bit_in(1, 1, "t4_b4"); bit_in(1, 1, "t4_b5"); bit_in(1, 1, "t4_b6");
    bit_in(1, 1, "t4_b7");
    chk(match_cnt, 8'd9, "t4_cnt");
    load(4'b1111, 1'b1, 1'b1, 1'b1);
    bit_in(1, 0, "t4_c1"); bit_in(1, 0, "t4_c2"); bit_in(1, 0, "t4_c3");
    bit_in(1, 1, "t4_c4");
    chk(match_cnt, 8'd10, "t4_cnt2");

    // 5: clear with valid data, pattern kept, saturation of the narrow counter
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, "t5_clr");
    chk(match_cnt, 8'd0, "t5_cnt_clr");
    chk(8'(match_cnt2), 8'd0, "t5_cnt2_clr");
    chk(8'(cnt_sat2), 8'd0, "t5_sat2_clr");
    bit_in(1, 0, "t5_b1"); bit_in(1, 0, "t5_b2"); bit_in(1, 0, "t5_b3");
    bit_in(1, 1, "t5_b4"); bit_in(1, 1, "t5_b5"); bit_in(1, 1, "t5_b6");
    bit_in(1, 1, "t5_b7"); bit_in(1, 1, "t5_b8");
    chk(match_cnt, 8'd5, "t5_cnt");
    chk(8'(cnt_sat), 8'd0, "t5_sat");
    chk(8'(match_cnt2), 8'd3, "t5_cnt2");
    chk(8'(cnt_sat2), 8'd1, "t5_sat2");
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_clr2");
    chk(8'(match_cnt2), 8'd0, "t5_cnt2_clr2");
    chk(8'(cnt_sat2), 8'd0, "t5_sat2_clr2");

    // 6: reset restores DEF_PATTERN and drops partial history
    bit_in(0, 0, "t6_a1"); bit_in(1, 0, "t6_a2"); bit_in(0, 0, "t6_a3");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bit_in(1, 0, "t6_b0");
    bit_in(0, 0, "t6_b1"); bit_in(1, 0, "t6_b2"); bit_in(0, 0, "t6_b3");
    bit_in(1, 1, "t6_b4");
    chk(match_cnt, 8'd1, "t6_cnt");
    // History now 101; 1,0,1,0 leaves 010 so a following 1 would match.
    bit_in(1, 0, "t6_c1"); bit_in(0, 0, "t6_c2"); bit_in(1, 0, "t6_c3");
    bit_in(0, 0, "t6_c4");
    reset_n = 1'b0; d_valid = 1'b1; d_in = 1'b1;
    #1;
    chk(8'(match), 8'h0, "t6_rst_match");
    chk(8'(match_q), 8'h0, "t6_rst_match_q");
    chk(match_cnt, 8'h0, "t6_rst_cnt");
    chk(8'(cnt_sat), 8'h0, "t6_rst_sat");
    @(negedge clk);
    reset_n = 1'b1; d_valid = 1'b0;
    bit_in(1, 0, "t6_d0");
    bit_in(0, 0, "t6_d1"); bit_in(1, 0, "t6_d2"); bit_in(0, 0, "t6_d3");
    bit_in(1, 1, "t6_d4");
    chk(match_cnt, 8'd1, "t6_cnt2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
